vga_sync_monitor: RTL and testbench
===================================

// Module: vga_sync_monitor
// PURPOSE
// - Receive end of the VGA sync interface: samples the active-low HSync/VSync that the sync generators drive.
// - Measures line/frame timing and recovers the pixel position (x, y).
// - Declares lock once timing matches the 840 000-tick frame for LOCK_FRAMES consecutive frames.
// - Used on-chip as a self-check of the timing chain and to qualify external sync sources.
// PARAMETERS
// H_PERIOD     1600    expected clocks per line (HSync fall to fall)
// V_LINES      525     expected lines per frame; frame = V_LINES*H_PERIOD = 840000 clocks
// VS_WIDTH     3200    expected VSync low width, clocks
// TOL          2       allowed +/- deviation, clocks, for every timing check
// LOCK_FRAMES  2       consecutive good frames needed to assert locked (>=1)
// CW           21      tick counter width; must hold 2*V_LINES*H_PERIOD
// PORTS
// clk             in   1    system clock
// reset_n         in   1    asynchronous active-low reset
// hsync_in        in   1    HSync, active-low, asynchronous to clk
// vsync_in        in   1    VSync, active-low, asynchronous to clk
// locked          out  1    timing verified
// line_start      out  1    1-clk pulse on each HSync fall event
// frame_start     out  1    1-clk pulse on each VSync fall event
// x_pos           out  CW   clocks since last HSync event
// y_pos           out  10   HSync events since last VSync event
// line_ticks      out  CW   last measured line period
// frame_ticks     out  CW   last measured frame period
// err             out  1    1-clk pulse: bad frame or timeout while locked
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - all outputs, counters and flags go to 0; FSM goes to SEARCH; synchronizer flops go to 1 (idle-high).
// - Input path:
//   - each sync input passes a 2-FF synchronizer, then a falling/rising edge detect.
//   - An edge event is registered 3 clk after the pin transitions; all times below are in event cycles.
// - x_pos:
//   - set to 0 in the hsync-fall event cycle; otherwise +1, saturating at 2^CW-1.
//   - line_ticks <= x_pos+1 at each hsync event, except the first event after reset (no capture).
// - y_pos:
//   - +1 per hsync event, saturating at 1023; cleared at a vsync-fall event.
//   - If hsync and vsync fall events coincide, the hsync counts in the closing frame and y_pos is then 0.
// - Frame counter f_cnt: same rules as x_pos, keyed on vsync fall; frame_ticks <= f_cnt+1 at each vsync event after the first.
// - VSync low width: counts clocks while synced vsync is 0; captured at the vsync rise; compared with VS_WIDTH+/-TOL.
// - Line check: sticky h_bad is set by any captured line_ticks outside H_PERIOD+/-TOL; cleared at each vsync event.
// - Good frame (evaluated at a vsync event): all of the following hold.
//   - |frame_ticks_new - V_LINES*H_PERIOD| <= TOL
//   - y_pos+coincident == V_LINES
//   - last VSync width ok
//   - h_bad==0
// - FSM:
//   - SEARCH: first vsync event -> ACQUIRE, good_cnt=0 (no frame judged).
//   - ACQUIRE: at each vsync event:
//     - good -> good_cnt+1;
//     - when good_cnt reaches LOCK_FRAMES -> LOCKED;
//     - bad -> good_cnt=0, stay.
//   - LOCKED: at a vsync event, bad -> ACQUIRE, good_cnt=0, err=1 for 1 clk.
//   - Any state: if f_cnt reaches 2*V_LINES*H_PERIOD with no vsync event -> SEARCH.
//     - err pulses if the FSM was in LOCKED.
// - locked = (state==LOCKED), registered; it drops in the same cycle err pulses.
// - Pulses line_start/frame_start are asserted in the event cycle; never wider than 1 clk.
// - Arithmetic: comparisons done unsigned at CW+1 bits to avoid wrap; the saturated counters never wrap.
// TESTING
// 1. Nominal 1600/525/3200 sync from generator chain:
//    - locked rises at the 3rd vsync fall event (LOCK_FRAMES=2);
//    - line_ticks=1600, frame_ticks=840000, err never set.
// 2. One line of 1603 clks inside frame 2 -> good_cnt resets; locked delayed by one frame.
//    - Same while locked -> err pulse, locked=0, relock after 2 good frames.
// 3. VSync held high after lock:
//    - at f_cnt=1680000, err pulses, state SEARCH, locked=0;
//    - next vsync fall -> ACQUIRE.
// 4. Frame of 840002 clks (within TOL) stays locked; 840003 -> err.
//    - VSync width 3198 ok, 3197 -> bad frame.
// 5. HSync and VSync falling in the same clk:
//    - y_pos=0 next cycle; closing frame counted 525 lines; still good.
// 6. reset_n pulled low mid-frame while locked:
//    - all outputs 0 immediately (async); after release, lock needs a full SEARCH+2 frames.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//   Receive side of the VGA sync interface. Samples the active-low HSync and
//   VSync, recovers the pixel position, measures line/frame/VSync-width timing
//   and declares lock after LOCK_FRAMES consecutive good frames.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   hsync_in     in   HSync, active-low, asynchronous to clk
//   vsync_in     in   VSync, active-low, asynchronous to clk
//   locked       out  timing verified (registered state==LOCKED)
//   line_start   out  1-clk pulse on each HSync fall event
//   frame_start  out  1-clk pulse on each VSync fall event
//   x_pos        out  clocks since last HSync fall event (saturating)
//   y_pos        out  HSync events since last VSync fall event (saturating)
//   line_ticks   out  last measured line period
//   frame_ticks  out  last measured frame period
//   err          out  1-clk pulse: bad frame or timeout while locked
//   state_dbg    out  current FSM state (SEARCH=0, ACQUIRE=1, LOCKED=2)
//
// Interface semantics: the sync inputs carry no handshake; they are level
// signals sampled every clk. Every output is registered except the two event
// pulses, which come straight from the registered edge detectors.
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int H_PERIOD    = 1600,
  parameter int V_LINES     = 525,
  parameter int VS_WIDTH    = 3200,
  parameter int TOL         = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 21
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic          locked,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] x_pos,
  output logic [9:0]    y_pos,
  output logic [CW-1:0] line_ticks,
  output logic [CW-1:0] frame_ticks,
  output logic          err,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int GW      = $clog2(LOCK_FRAMES + 1);
  localparam int FRAME_I = V_LINES * H_PERIOD;

  // Window limits held at CW+1 bits so x+1 / f+1 can never wrap into range.
  localparam logic [CW:0]   FR_LO = (CW+1)'(FRAME_I - TOL);
  localparam logic [CW:0]   FR_HI = (CW+1)'(FRAME_I + TOL);
  localparam logic [CW:0]   LN_LO = (CW+1)'(H_PERIOD - TOL);
  localparam logic [CW:0]   LN_HI = (CW+1)'(H_PERIOD + TOL);
  localparam logic [CW:0]   VS_LO = (CW+1)'(VS_WIDTH - TOL);
  localparam logic [CW:0]   VS_HI = (CW+1)'(VS_WIDTH + TOL);
  localparam logic [CW-1:0] TMO   = CW'(2 * FRAME_I);
  localparam logic [10:0]   V_LINES_L = 11'(V_LINES);

  // Synchronizers (idle-high) plus one extra stage for edge detection.
  logic hs_s1_q, hs_s2_q, hs_s3_q, hs_ev_q;
  logic vs_s1_q, vs_s2_q, vs_s3_q, vs_fall_q, vs_rise_q;

  logic [CW-1:0] x_q, f_q, lt_q, ft_q;
  logic [9:0]    y_q;
  logic          h_seen_q, v_seen_q, h_bad_q, vs_ok_q;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic          locked_q, err_q, err_d;

  logic [CW:0]   line_new, frame_new;
  logic [10:0]   lines_c;
  logic          line_bad_c, vs_w_ok_c, frame_good_c, timeout_c;

  assign line_new  = {1'b0, x_q} + (CW+1)'(1);
  assign frame_new = {1'b0, f_q} + (CW+1)'(1);
  // A line that closes in the same cycle as the frame belongs to that frame.
  assign lines_c   = {1'b0, y_q} + 11'(hs_ev_q);

  assign line_bad_c = h_seen_q && ((line_new < LN_LO) || (line_new > LN_HI));
  // f_q restarts at the VSync fall, so at the rise f_q+1 is the low width.
  assign vs_w_ok_c  = (frame_new >= VS_LO) && (frame_new <= VS_HI);
  assign timeout_c  = (f_q == TMO);

  assign frame_good_c = (frame_new >= FR_LO) && (frame_new <= FR_HI) &&
                        (lines_c == V_LINES_L) && vs_ok_q &&
                        !(h_bad_q || (hs_ev_q && line_bad_c));

  assign good_inc = good_q + GW'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (vs_fall_q) begin
      case (state_q)
        SEARCH: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          if (frame_good_c) begin
            good_d = good_inc;
            if (good_inc >= GW'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!frame_good_c) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end else if (timeout_c) begin
      // No VSync for two nominal frames: source lost.
      state_d = SEARCH;
      good_d  = '0;
      err_d   = (state_q == LOCKED);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1_q   <= 1'b1;
      hs_s2_q   <= 1'b1;
      hs_s3_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_s3_q   <= 1'b1;
      hs_ev_q   <= 1'b0;
      vs_fall_q <= 1'b0;
      vs_rise_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      f_q       <= '0;
      lt_q      <= '0;
      ft_q      <= '0;
      h_seen_q  <= 1'b0;
      v_seen_q  <= 1'b0;
      h_bad_q   <= 1'b0;
      vs_ok_q   <= 1'b0;
      state_q   <= SEARCH;
      good_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hs_s1_q   <= hsync_in;
      hs_s2_q   <= hs_s1_q;
      hs_s3_q   <= hs_s2_q;
      vs_s1_q   <= vsync_in;
      vs_s2_q   <= vs_s1_q;
      vs_s3_q   <= vs_s2_q;
      hs_ev_q   <= hs_s3_q & ~hs_s2_q;
      vs_fall_q <= vs_s3_q & ~vs_s2_q;
      vs_rise_q <= ~vs_s3_q & vs_s2_q;

      // Horizontal position and line period.
      if (hs_ev_q) begin
        x_q      <= '0;
        h_seen_q <= 1'b1;
        if (h_seen_q) lt_q <= line_new[CW] ? '1 : line_new[CW-1:0];
      end else if (x_q != '1) begin
        x_q <= x_q + CW'(1);
      end

      // Line counter: a coincident VSync clears it after the closing line
      // was already accounted for in lines_c.
      if (vs_fall_q) begin
        y_q <= '0;
      end else if (hs_ev_q && (y_q != 10'h3FF)) begin
        y_q <= y_q + 10'd1;
      end

      // Sticky bad-line flag, scoped to one frame.
      if (vs_fall_q) begin
        h_bad_q <= 1'b0;
      end else if (hs_ev_q && line_bad_c) begin
        h_bad_q <= 1'b1;
      end

      // Frame counter and frame period.
      if (vs_fall_q) begin
        f_q      <= '0;
        v_seen_q <= 1'b1;
        if (v_seen_q) ft_q <= frame_new[CW] ? '1 : frame_new[CW-1:0];
      end else if (f_q != '1) begin
        f_q <= f_q + CW'(1);
      end

      if (vs_rise_q) vs_ok_q <= vs_w_ok_c;

      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_d;
    end
  end

  assign locked      = locked_q;
  assign line_start  = hs_ev_q;
  assign frame_start = vs_fall_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign line_ticks  = lt_q;
  assign frame_ticks = ft_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_monitor
//   Scaled-down timing (20 clk lines, 10 lines, 40 clk VSync, TOL 2) so a run
//   spans ~26 frames in a few thousand clocks. A generator process produces
//   the sync waveform from a per-frame table; the main process samples the
//   DUT at fixed frame/clock positions against hand-computed values.
//   Pins are driven at negedge; sampling is 2 time units after posedge.
//   A pin change at frame clock 0 shows as an event pulse at clock 2 and as
//   updated registers at clock 3.
// -----------------------------------------------------------------------------
module tb_vga_sync_monitor;

  localparam int H   = 20;
  localparam int V   = 10;
  localparam int VSW = 40;
  localparam int TOL = 2;
  localparam int LF  = 2;
  localparam int CW  = 10;
  localparam int WAIT_LIMIT = 20000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hsync_in, vsync_in;
  logic          locked, line_start, frame_start, err;
  logic [CW-1:0] x_pos, line_ticks, frame_ticks;
  logic [9:0]    y_pos;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int gen_frame = 0;
  int gen_fc = 0;
  bit gen_run = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_PERIOD(H), .V_LINES(V), .VS_WIDTH(VSW), .TOL(TOL),
    .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .locked(locked),
    .line_start(line_start),
    .frame_start(frame_start),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .line_ticks(line_ticks),
    .frame_ticks(frame_ticks),
    .err(err),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the posedge at which the generator sits on frame f clock c.
  task automatic wait_at(input int f, input int c);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(gen_frame == f && gen_fc == c) && n < WAIT_LIMIT);
    #2;
    if (n >= WAIT_LIMIT) chk("wait_pos", gen_frame * 1000 + gen_fc, f * 1000 + c);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lstart"}, line_start, 0);
    chk({tag, "_fstart"}, frame_start, 0);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_y"}, y_pos, 0);
    chk({tag, "_lticks"}, line_ticks, 0);
    chk({tag, "_fticks"}, frame_ticks, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- sync generator ----------------
  // Per-frame table: bad line (+3 clk on line 5), extra clocks spread over
  // lines 0/1 (each within TOL), VSync width, or VSync held high.
  initial begin
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    wait (gen_run);
    forever begin
      int bad_l, ext, vw, fc, len;
      bit hold;
      bad_l = -1; ext = 0; vw = VSW; hold = 1'b0;
      case (gen_frame)
        4, 22:  bad_l = 5;
        7:      ext = 2;
        8:      ext = 3;
        11:     vw = 38;
        12:     vw = 37;
        16, 17: hold = 1'b1;
        default: ;
      endcase
      fc = 0;
      for (int l = 0; l < V; l++) begin
        len = H + ((l == bad_l) ? 3 : 0)
                + ((l == 0) ? ((ext > 2) ? 2 : ext) : 0)
                + ((l == 1) ? ((ext > 2) ? ext - 2 : 0) : 0);
        for (int c = 0; c < len; c++) begin
          @(negedge clk);
          hsync_in = (c < 3) ? 1'b0 : 1'b1;
          vsync_in = (!hold && fc < vw) ? 1'b0 : 1'b1;
          gen_fc = fc;
          fc++;
        end
      end
      gen_frame++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("rst");
    reset_n = 1'b1;
    gen_run = 1'b1;

    // First VSync: SEARCH -> ACQUIRE, no frame judged.
    wait_at(0, 2);
    chk("f0_fstart", frame_start, 1);
    chk("f0_lstart", line_start, 1);
    wait_at(0, 3);
    chk("f0_state", state_dbg, 1);
    chk("f0_locked", locked, 0);
    chk("f0_fstart_w", frame_start, 0);
    chk("f0_y", y_pos, 0);
    chk("f0_x", x_pos, 0);

    wait_at(1, 3);
    chk("f1_state", state_dbg, 1);
    chk("f1_locked", locked, 0);
    chk("f1_fticks", frame_ticks, 200);
    chk("f1_lticks", line_ticks, 20);
    chk("f1_err", err, 0);

    // Lock at the third VSync event.
    wait_at(2, 3);
    chk("f2_locked", locked, 1);
    chk("f2_state", state_dbg, 2);
    chk("f2_err", err, 0);
    wait_at(2, 13);
    chk("f2_x10", x_pos, 10);
    chk("f2_y0", y_pos, 0);
    wait_at(2, 82);
    chk("f2_lstart", line_start, 1);
    chk("f2_fstart", frame_start, 0);
    wait_at(2, 83);
    chk("f2_y4", y_pos, 4);
    chk("f2_x0", x_pos, 0);
    chk("f2_lstart_w", line_start, 0);

    wait_at(3, 3);
    chk("f3_locked", locked, 1);
    chk("f3_err", err, 0);

    // 23-clk line in frame 4 while locked.
    wait_at(4, 126);
    chk("f4_lticks", line_ticks, 23);
    wait_at(5, 3);
    chk("f5_err", err, 1);
    chk("f5_locked", locked, 0);
    chk("f5_state", state_dbg, 1);
    chk("f5_fticks", frame_ticks, 203);
    wait_at(5, 4);
    chk("f5_err_w", err, 0);
    wait_at(6, 3);
    chk("f6_locked", locked, 0);
    wait_at(7, 3);
    chk("f7_relock", locked, 1);
    chk("f7_err", err, 0);

    // Frame length +2 stays locked, +3 breaks lock.
    wait_at(8, 3);
    chk("f8_locked", locked, 1);
    chk("f8_fticks", frame_ticks, 202);
    chk("f8_err", err, 0);
    wait_at(9, 3);
    chk("f9_err", err, 1);
    chk("f9_locked", locked, 0);
    chk("f9_fticks", frame_ticks, 203);
    wait_at(11, 3);
    chk("f11_relock", locked, 1);

    // VSync width 38 ok, 37 bad.
    wait_at(12, 3);
    chk("f12_locked", locked, 1);
    chk("f12_err", err, 0);
    wait_at(13, 3);
    chk("f13_err", err, 1);
    chk("f13_locked", locked, 0);
    wait_at(15, 3);
    chk("f15_relock", locked, 1);

    // VSync held high for frames 16/17: timeout 400 clk after the last event.
    wait_at(17, 3);
    chk("tmo_pre_locked", locked, 1);
    chk("tmo_pre_err", err, 0);
    chk("tmo_pre_state", state_dbg, 2);
    wait_at(17, 4);
    chk("tmo_err", err, 1);
    chk("tmo_locked", locked, 0);
    chk("tmo_state", state_dbg, 0);
    wait_at(17, 5);
    chk("tmo_err_w", err, 0);
    wait_at(18, 3);
    chk("f18_state", state_dbg, 1);
    chk("f18_locked", locked, 0);
    chk("f18_err", err, 0);

    // Coincident HSync/VSync: closing line counted, y cleared.
    wait_at(19, 2);
    chk("coin_y9", y_pos, 9);
    chk("coin_fstart", frame_start, 1);
    chk("coin_lstart", line_start, 1);
    wait_at(19, 3);
    chk("coin_y0", y_pos, 0);
    wait_at(20, 3);
    chk("f20_locked", locked, 1);

    // Asynchronous reset mid-frame while locked.
    wait_at(21, 50);
    chk("f21_x7", x_pos, 7);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    wait_at(21, 55);
    reset_n = 1'b1;

    // SEARCH, then a bad-line frame delays lock by one frame.
    wait_at(22, 3);
    chk("f22_state", state_dbg, 1);
    chk("f22_locked", locked, 0);
    wait_at(23, 3);
    chk("f23_locked", locked, 0);
    chk("f23_state", state_dbg, 1);
    wait_at(24, 3);
    chk("f24_locked", locked, 0);
    wait_at(25, 3);
    chk("f25_locked", locked, 1);
    chk("f25_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
